multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and no parameters.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces state FETCH.
REQ-004 op  input  7  instruction opcode field (Instr[6:0]) from the instruction register.
REQ-005 funct3  input  3  instruction funct3 field.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 MemReady  input  1  memory handshake; 1 = current read/write access completes this cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and select.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUControl  output  3  ALU operation.
REQ-012 IllegalOp  output  1  one-cycle pulse in DECODE when op is unsupported.
REQ-013 State  output  4  current state code, for debug.

Function
REQ-014 States and codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next clock.
REQ-015 State transitions SHALL be:
- FETCH->DECODE when MemReady=1, else stay in FETCH.
- DECODE: lw/sw (0000011/0100011)->MEMADR; R-type (0110011)->EXECUTER; I-type ALU (0010011)->EXECUTEI; beq (1100011)->BEQ; jal (1101111)->JAL; any other op->FETCH with IllegalOp=1.
- MEMADR: lw->MEMREAD, sw->MEMWRITE.
- MEMREAD->MEMWB when MemReady=1, else stay.
- MEMWRITE->FETCH when MemReady=1, else stay.
- EXECUTER, EXECUTEI, JAL->ALUWB.
- MEMWB, ALUWB, BEQ->FETCH.
REQ-016 Each output SHALL default to 0 in every state unless set below.
REQ-017 Per-state outputs (ALUOp is internal):
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PCUpdate=1 only while MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, held until the exit cycle.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-018 PCWrite SHALL equal PCUpdate OR (Branch AND Zero).
REQ-019 ImmSrc SHALL decode combinationally from op in all states: lw/I-type=00, sw=01, beq=10, jal=11, other=00.
REQ-020 ALUControl SHALL decode as follows:
- ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
- ALUOp 10, funct3 000 -> 001 if op[5] AND funct7b5, else 000.
- ALUOp 10, funct3 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); other funct3 -> 000.
- ALUOp 11 -> 000.
REQ-021 Outputs SHALL be combinational from State, op, funct3, funct7b5, Zero and MemReady; the only register is State.
REQ-022 Stall states SHALL hold every output stable for the whole stall.

Reset
REQ-023 reset=0 SHALL set State=FETCH immediately, independent of clk.
REQ-024 While reset=0, PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp SHALL be forced to 0; the other outputs SHALL show FETCH values.
REQ-025 Reset asserted in any state, including a MEMWRITE stall, SHALL abort the operation with no further write enable; after release the block SHALL start at FETCH on the next clk edge.

Verification
REQ-026 lw (op=0000011), MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01.
REQ-027 sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, AdrSrc=1 throughout, then FETCH.
REQ-028 R-type sub (funct3=000, funct7b5=1) -> EXECUTER with ALUControl=001, then ALUWB with RegWrite=1; same fields with op=0010011 -> ALUControl=000.
REQ-029 beq in BEQ state -> Zero=1 gives PCWrite=1; Zero=0 gives PCWrite=0; next state FETCH in both cases.
REQ-030 op=0000000 in DECODE -> IllegalOp=1 for one cycle, next state FETCH, no write enable asserted.
REQ-031 reset=0 pulsed mid-cycle during MEMREAD -> State=0 asynchronously, write enables 0; after release, FETCH with MemReady=1 gives IRWrite=1 and PCWrite=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: a single state register plus combinational
// decode of datapath enables, mux selects, immediate format and ALU operation.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalOp,
  output logic [3:0] State
);

  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  state_t     stateQ, stateD;
  logic       pcUpdate, branch;
  logic       irWriteRaw, regWriteRaw, memWriteRaw, illegalRaw;
  logic [1:0] aluOp;

  // State register; reset drops straight to FETCH without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= FETCH;
    else        stateQ <= stateD;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    stateD      = FETCH;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    aluOp       = 2'b00;
    unique case (stateQ)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        irWriteRaw = MemReady;
        pcUpdate   = MemReady;
        stateD     = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: stateD = MEMADR;
          OpRType:    stateD = EXECUTER;
          OpIType:    stateD = EXECUTEI;
          OpBeq:      stateD = BEQ;
          OpJal:      stateD = JAL;
          default: begin
            stateD     = FETCH;
            illegalRaw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        stateD  = (op == OpSw) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        stateD = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        stateD      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        stateD      = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
        stateD  = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
        stateD  = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        stateD      = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
        stateD  = FETCH;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
        stateD   = ALUWB;
      end
      default: stateD = FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU operation decode from ALUOp and the instruction function fields.
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Write enables and the illegal pulse are masked while reset is held so an
  // aborted access cannot commit; the selects keep showing FETCH values.
  assign PCWrite   = reset & (pcUpdate | (branch & Zero));
  assign IRWrite   = reset & irWriteRaw;
  assign RegWrite  = reset & regWriteRaw;
  assign MemWrite  = reset & memWriteRaw;
  assign IllegalOp = reset & illegalRaw;
  assign State     = stateQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// state trace, the outputs of every cycle are checked against a rule-based
// model, and a few directed scenarios pin literal values.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010,
                         OR_ = 3'b011, SLT = 3'b101;

  typedef struct packed {
    logic       pcW, adrS, memW, irW, regW;
    logic [1:0] resS, srcA, srcB, imm;
    logic [2:0] aluC;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, MemReady;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int vectors = 0;
  int miscompares = 0;
  outs_t logQ[$];

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalOp(IllegalOp),
    .State(State)
  );

  always #5 clk = ~clk;

  function automatic logic known(input logic [6:0] o);
    return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
           o == OP_BEQ || o == OP_JAL;
  endfunction

  // Expected outputs from the state the trace says we are in and the inputs.
  function automatic outs_t model(input int st, input logic [6:0] o,
                                  input logic [2:0] f3, input logic f7,
                                  input logic z, input logic mr, input logic rn);
    outs_t e;
    logic [2:0] fieldOp;
    e = '0;
    e.st = 4'(st);
    e.imm = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 :
            (o == OP_JAL) ? 2'b11 : 2'b00;
    case (f3)
      3'b000:  fieldOp = (o[5] && f7) ? SUB : ADD;
      3'b010:  fieldOp = SLT;
      3'b110:  fieldOp = OR_;
      3'b111:  fieldOp = AND_;
      default: fieldOp = ADD;
    endcase
    case (st)
      0: begin e.srcB = 2; e.resS = 2; e.irW = mr; e.pcW = mr; end
      1: begin e.srcA = 1; e.srcB = 1; e.ill = !known(o); end
      2: begin e.srcA = 2; e.srcB = 1; end
      3: e.adrS = 1;
      4: begin e.resS = 1; e.regW = 1; end
      5: begin e.adrS = 1; e.memW = 1; end
      6: begin e.srcA = 2; e.aluC = fieldOp; end
      7: begin e.srcA = 2; e.srcB = 1; e.aluC = fieldOp; end
      8: e.regW = 1;
      9: begin e.srcA = 2; e.aluC = SUB; e.pcW = z; end
      10: begin e.srcA = 1; e.srcB = 2; e.pcW = 1; end
      default: ;
    endcase
    if (!rn) begin
      e.pcW = 0; e.irW = 0; e.regW = 0; e.memW = 0; e.ill = 0;
    end
    return e;
  endfunction

  task automatic check(input int st);
    outs_t e, a;
    e = model(st, op, funct3, funct7b5, Zero, MemReady, reset);
    a = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
         ALUSrcB, ImmSrc, ALUControl, IllegalOp, State};
    logQ.push_back(a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL cycle t=%0t st=%0d op=%b f3=%b mr=%b z=%b: got %h expected %h",
               $time, st, op, funct3, MemReady, Zero, a, e);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doCycle(input int st, input logic mr, input logic z,
                         input logic [6:0] o, input logic [2:0] f3, input logic f7);
    @(posedge clk);
    #2;
    MemReady = mr; Zero = z; op = o; funct3 = f3; funct7b5 = f7;
    #3;
    check(st);
  endtask

  // Expand one instruction into its expected state/MemReady trace and run it.
  task automatic runInstr(input logic [6:0] o, input int fs, input int ms,
                          input logic [2:0] f3, input logic f7, input logic z);
    int sq[$];
    logic mq[$];
    for (int i = 0; i < fs; i++) begin sq.push_back(0); mq.push_back(0); end
    sq.push_back(0); mq.push_back(1);
    sq.push_back(1); mq.push_back(1'($urandom));
    case (o)
      OP_LW: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin sq.push_back(3); mq.push_back(0); end
        sq.push_back(3); mq.push_back(1);
        sq.push_back(4); mq.push_back(1'($urandom));
      end
      OP_SW: begin
        sq.push_back(2); mq.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin sq.push_back(5); mq.push_back(0); end
        sq.push_back(5); mq.push_back(1);
      end
      OP_R:   begin sq.push_back(6); mq.push_back(1'($urandom));
                    sq.push_back(8); mq.push_back(1'($urandom)); end
      OP_I:   begin sq.push_back(7); mq.push_back(1'($urandom));
                    sq.push_back(8); mq.push_back(1'($urandom)); end
      OP_BEQ: begin sq.push_back(9); mq.push_back(1'($urandom)); end
      OP_JAL: begin sq.push_back(10); mq.push_back(1'($urandom));
                    sq.push_back(8); mq.push_back(1'($urandom)); end
      default: ;
    endcase
    foreach (sq[i]) doCycle(sq[i], mq[i], z, o, f3, f7);
  endtask

  function automatic logic [6:0] randOp();
    logic [6:0] tbl[10];
    tbl = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL,
            7'b0000000, 7'b0110111, 7'b1100111, 7'b1111111};
    return tbl[$urandom_range(0, 9)];
  endfunction

  initial begin
    int cnt, adrOk, seen;
    int lwStates[5];
    lwStates = '{0, 1, 2, 3, 4};

    // Reset held with MemReady high: FETCH selects, no enables.
    reset = 1'b0; MemReady = 1'b1; Zero = 1'b0; op = OP_LW;
    funct3 = 3'b000; funct7b5 = 1'b0;
    #1;
    chk("resetState", int'(State), 0);
    chk("resetIRWrite", int'(IRWrite), 0);
    chk("resetPCWrite", int'(PCWrite), 0);
    check(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(0);
    #1; MemReady = 1'b0; reset = 1'b1;

    // lw, no stalls.
    logQ.delete();
    runInstr(OP_LW, 0, 0, 3'b010, 1'b0, 1'b0);
    chk("lwLen", logQ.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("lwState", int'(logQ[i].st), lwStates[i]);
      chk("lwRegWrite", int'(logQ[i].regW), (i == 4) ? 1 : 0);
    end
    chk("lwResultSrc", int'(logQ[4].resS), 1);

    // sw with three MemReady=0 cycles in MEMWRITE.
    logQ.delete();
    runInstr(OP_SW, 1, 3, 3'b010, 1'b0, 1'b0);
    cnt = 0; adrOk = 0;
    foreach (logQ[i]) if (logQ[i].memW) begin
      cnt++;
      if (logQ[i].adrS) adrOk++;
    end
    chk("swMemWriteCycles", cnt, 4);
    chk("swAdrSrc", adrOk, 4);

    // sub as R-type, then same fields as I-type.
    logQ.delete();
    runInstr(OP_R, 0, 0, 3'b000, 1'b1, 1'b0);
    seen = 0;
    foreach (logQ[i]) if (logQ[i].st == 4'd6) seen = int'(logQ[i].aluC);
    chk("rSubAluCtl", seen, 1);
    chk("rAluwbRegWrite", int'(logQ[logQ.size()-1].regW), 1);
    logQ.delete();
    runInstr(OP_I, 0, 0, 3'b000, 1'b1, 1'b0);
    seen = 7;
    foreach (logQ[i]) if (logQ[i].st == 4'd7) seen = int'(logQ[i].aluC);
    chk("iAddAluCtl", seen, 0);

    // beq taken and not taken.
    logQ.delete();
    runInstr(OP_BEQ, 0, 0, 3'b000, 1'b0, 1'b1);
    chk("beqTakenPCWrite", int'(logQ[logQ.size()-1].pcW), 1);
    logQ.delete();
    runInstr(OP_BEQ, 0, 0, 3'b000, 1'b0, 1'b0);
    chk("beqNotTakenPCWrite", int'(logQ[logQ.size()-1].pcW), 0);

    // Illegal opcode: single pulse in DECODE, no writes there.
    logQ.delete();
    runInstr(7'b0000000, 0, 0, 3'b000, 1'b0, 1'b0);
    cnt = 0;
    foreach (logQ[i]) cnt += int'(logQ[i].ill);
    chk("illegalPulses", cnt, 1);
    chk("illegalNoWrite", int'(logQ[1].regW) + int'(logQ[1].memW) +
        int'(logQ[1].pcW) + int'(logQ[1].irW), 0);
    runInstr(OP_JAL, 0, 0, 3'b000, 1'b0, 1'b0);

    // Reset pulsed between clock edges while in MEMREAD.
    doCycle(0, 1, 0, OP_LW, 3'b010, 1'b0);
    doCycle(1, 0, 0, OP_LW, 3'b010, 1'b0);
    doCycle(2, 0, 0, OP_LW, 3'b010, 1'b0);
    doCycle(3, 0, 0, OP_LW, 3'b010, 1'b0);
    #1; reset = 1'b0; MemReady = 1'b1;
    #1;
    chk("midResetState", int'(State), 0);
    chk("midResetWrites", int'(RegWrite) + int'(MemWrite) + int'(IRWrite) +
        int'(PCWrite), 0);
    check(0);
    #1; MemReady = 1'b0; reset = 1'b1;
    doCycle(0, 1, 0, OP_LW, 3'b010, 1'b0);
    chk("postResetIRWrite", int'(IRWrite), 1);
    chk("postResetPCWrite", int'(PCWrite), 1);
    doCycle(1, 0, 0, OP_LW, 3'b010, 1'b0);
    doCycle(2, 0, 0, OP_LW, 3'b010, 1'b0);
    doCycle(3, 1, 0, OP_LW, 3'b010, 1'b0);
    doCycle(4, 0, 0, OP_LW, 3'b010, 1'b0);

    // Random instruction stream.
    for (int n = 0; n < 400; n++) begin
      runInstr(randOp(), $urandom_range(0, 2), $urandom_range(0, 3),
               3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
